// File: rtl/fir_pkg.sv
// Shared constants for the 64-tap FIR MAC sequencer, its datapath and bench.
package fir_pkg;

  localparam int TAPS = 64;
  localparam int AW   = $clog2(TAPS);

  typedef logic [1:0] state_t;

  localparam state_t COEF  = 2'd0;
  localparam state_t READY = 2'd1;
  localparam state_t RUN   = 2'd2;

endpackage

// File: rtl/fir_tap_counter.sv
// Wrapping AW-bit counter with synchronous clear, enable and terminal-count flag.
module fir_tap_counter #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] count,
  output logic          tc
);

  // Clear has priority over enable; the count wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = &count;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Control FSM for the FIR MAC datapath: coefficient streaming, delay-line
// pointer management and per-sample MAC sequencing in the clk2 domain.
module fir_mac_sequencer #(
  parameter int TAPS = 64,
  parameter int AW   = $clog2(TAPS)
) (
  input  logic          clk2,
  input  logic          ALU_restn,
  input  logic          b_valid,
  input  logic          coef_reload,
  input  logic          sample_tick,
  output logic          coef_we,
  output logic [AW-1:0] coef_waddr,
  output logic [AW-1:0] coef_raddr,
  output logic          x_we,
  output logic [AW-1:0] x_waddr,
  output logic [AW-1:0] tap_raddr,
  output logic          tap_bypass,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          y_latch,
  output logic          busy,
  output logic          coef_ready,
  output logic          overrun
);
  import fir_pkg::*;

  state_t        state;
  logic [AW-1:0] k;
  logic [AW-1:0] cnt;
  logic          k_tc;
  logic          cnt_tc;
  logic [AW-1:0] x_ptr;
  logic          pending;
  logic          reload_pend;
  logic          overrun_r;
  logic          coef_ready_r;
  logic          y_latch_r;

  logic          in_coef;
  logic          in_run;
  logic          coef_wr;
  logic          first_tap;

  assign in_coef   = (state == COEF);
  assign in_run    = (state == RUN);
  // A reload pulse in COEF restarts the load, so the word on the bus that cycle is dropped.
  assign coef_wr   = in_coef & b_valid & ~coef_reload & ALU_restn;
  assign first_tap = in_run & (k == '0);

  fir_tap_counter #(.AW(AW)) u_k_cnt (
    .clk   (clk2),
    .rst_n (ALU_restn),
    .clr   (~in_run),
    .en    (in_run),
    .count (k),
    .tc    (k_tc)
  );

  fir_tap_counter #(.AW(AW)) u_coef_cnt (
    .clk   (clk2),
    .rst_n (ALU_restn),
    .clr   (~in_coef | coef_reload),
    .en    (coef_wr),
    .count (cnt),
    .tc    (cnt_tc)
  );

  // Sequencer state, delay-line pointer and the pending/reload/overrun bookkeeping.
  always_ff @(posedge clk2 or negedge ALU_restn) begin
    if (!ALU_restn) begin
      state        <= COEF;
      x_ptr        <= '0;
      pending      <= 1'b0;
      reload_pend  <= 1'b0;
      overrun_r    <= 1'b0;
      coef_ready_r <= 1'b0;
      y_latch_r    <= 1'b0;
    end else begin
      y_latch_r <= in_run & k_tc;
      case (state)
        COEF: begin
          if (coef_wr && cnt_tc) begin
            state        <= READY;
            coef_ready_r <= 1'b1;
          end
        end
        READY: begin
          if (coef_reload) begin
            state        <= COEF;
            coef_ready_r <= 1'b0;
          end else if (sample_tick) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (k_tc) begin
            x_ptr <= x_ptr + 1'b1;
            if (reload_pend || coef_reload) begin
              state        <= COEF;
              coef_ready_r <= 1'b0;
              reload_pend  <= 1'b0;
              pending      <= 1'b0;
            end else if (sample_tick || pending) begin
              state   <= RUN;
              pending <= 1'b0;
              if (sample_tick && pending) begin
                overrun_r <= 1'b1;
              end
            end else begin
              state <= READY;
            end
          end else begin
            if (coef_reload) begin
              reload_pend <= 1'b1;
            end
            if (sample_tick) begin
              if (pending) begin
                overrun_r <= 1'b1;
              end else begin
                pending <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= COEF;
        end
      endcase
    end
  end

  assign coef_we    = coef_wr;
  assign coef_waddr = cnt;
  assign coef_raddr = k;
  assign x_we       = first_tap;
  assign x_waddr    = x_ptr;
  assign tap_raddr  = x_ptr - k;
  assign tap_bypass = first_tap;
  assign mac_clr    = first_tap;
  assign mac_en     = in_run;
  assign y_latch    = y_latch_r;
  assign busy       = in_run;
  assign coef_ready = coef_ready_r;
  assign overrun    = overrun_r;

endmodule
